// File: rtl/uart_pkg.sv
// Shared types and helpers for the board-side UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_BITS = 8;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: free-running modulo-CLKS_PER_BIT counter with a restart
// input; bit_done marks the last cycle of each bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic hz100,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;

  // Next count: restart wins, otherwise wrap at the end of the bit period.
  always_comb begin
    count_s = count_r;
    if (restart) begin
      count_s = {CNT_W{1'b0}};
    end else if (count_r == LAST) begin
      count_s = {CNT_W{1'b0}};
    end else begin
      count_s = count_r + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_s;
    end
  end

  assign bit_done = (count_r == LAST);

endmodule

// File: rtl/uart_tx_port.sv
// UART transmitter for the student byte interface (txdata/txclk/txready).
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic       hz100,
  input  logic       reset,
  input  logic [7:0] txdata,
  input  logic       txclk,
  output logic       txready,
  output logic       txd,
  output logic       tx_overrun
);

  tx_state_t  state_r, state_s;
  logic [7:0] shift_r, shift_s;
  logic [2:0] bit_idx_r, bit_idx_s;
  logic       stop_idx_r, stop_idx_s;
  logic       txd_r, txd_s;
  logic       txready_r, txready_s;
  logic       overrun_r, overrun_s;
  logic       txclk_q_r;
  logic       rise_s;
  logic       restart_s;
  logic       bit_done_s;
`ifdef UART_TX_PARITY_EN
  logic       parity_r, parity_s;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .hz100   (hz100),
    .reset   (reset),
    .restart (restart_s),
    .bit_done(bit_done_s)
  );

  assign rise_s = txclk & ~txclk_q_r;

  // Next-state, shift register and registered line level.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_idx_s  = bit_idx_r;
    stop_idx_s = stop_idx_r;
    txd_s      = txd_r;
    restart_s  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_s   = parity_r;
`endif
    // A strobe while busy is dropped but remembered.
    if (rise_s && (state_r != IDLE)) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = overrun_r;
    end

    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_s   = START;
          shift_s   = txdata;
          overrun_s = 1'b0;
          restart_s = 1'b1;
          txd_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_s  = even_parity(txdata);
`endif
        end else begin
          txd_s = 1'b1;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_s   = DATA;
          bit_idx_s = 3'd0;
          txd_s     = shift_r[0];
          shift_s   = {1'b0, shift_r[7:1]};
        end else begin
          txd_s = 1'b0;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          if (bit_idx_r == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_s    = PARITY;
            txd_s      = parity_r;
`else
            state_s    = STOP;
            stop_idx_s = 1'b0;
            txd_s      = 1'b1;
`endif
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
            txd_s     = shift_r[0];
            shift_s   = {1'b0, shift_r[7:1]};
          end
        end else begin
          txd_s = txd_r;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done_s) begin
          state_s    = STOP;
          stop_idx_s = 1'b0;
          txd_s      = 1'b1;
        end else begin
          txd_s = parity_r;
        end
      end
`endif
      STOP: begin
        txd_s = 1'b1;
        if (bit_done_s) begin
          if (stop_idx_r == 1'(STOP_BITS - 1)) begin
            state_s = IDLE;
          end else begin
            stop_idx_s = stop_idx_r + 1'b1;
          end
        end else begin
          stop_idx_s = stop_idx_r;
        end
      end
      default: begin
        state_s = IDLE;
        txd_s   = 1'b1;
      end
    endcase

    txready_s = (state_s == IDLE);
  end

  // State and datapath registers; txclk_q resets high so a held strobe is not an edge.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      shift_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      txd_r      <= 1'b1;
      txready_r  <= 1'b1;
      overrun_r  <= 1'b0;
      txclk_q_r  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_idx_r  <= bit_idx_s;
      stop_idx_r <= stop_idx_s;
      txd_r      <= txd_s;
      txready_r  <= txready_s;
      overrun_r  <= overrun_s;
      txclk_q_r  <= txclk;
`ifdef UART_TX_PARITY_EN
      parity_r   <= parity_s;
`endif
    end
  end

  assign txd        = txd_r;
  assign txready    = txready_r;
  assign tx_overrun = overrun_r;

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: one-stop and two-stop instances share stimulus and
// are compared every cycle against a frame-timing model.
module tb_uart_tx_port;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       hz100 = 1'b0;
  logic       reset;
  logic       txclk;
  logic [7:0] txdata;
  logic       txready0, txd0, ovr0;
  logic       txready1, txd1, ovr1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state per instance (0: one stop bit, 1: two stop bits).
  int         m_acc [2];
  logic [7:0] m_data[2];
  logic       m_ovr [2];
  logic       m_prev;

  always #5 hz100 = ~hz100;

  uart_tx_port #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
    .hz100(hz100), .reset(reset), .txdata(txdata), .txclk(txclk),
    .txready(txready0), .txd(txd0), .tx_overrun(ovr0)
  );

  uart_tx_port #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
    .hz100(hz100), .reset(reset), .txdata(txdata), .txclk(txclk),
    .txready(txready1), .txd(txd1), .tx_overrun(ovr1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int flen(input int sb);
    return (1 + 8 + PAR + sb) * CPB;
  endfunction

  function automatic logic busy(input int j, input int a, input int sb);
    return (j > a) && (j <= a + flen(sb));
  endfunction

  // Line level in cycle j for a frame accepted at the end of cycle a.
  function automatic logic exp_txd(input int j, input int a, input int sb, input logic [7:0] d);
    int off;
    int bp;
    off = j - a - 1;
    if (off < 0 || off >= flen(sb)) return 1'b1;
    bp = off / CPB;
    if (bp == 0) return 1'b0;
    if (bp <= 8) return d[bp-1];
    if (PAR == 1 && bp == 9) return ^d;
    return 1'b1;
  endfunction

  always @(posedge hz100) cyc <= cyc + 1;

  always @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      m_prev <= 1'b1;
      for (int m = 0; m < 2; m++) begin
        m_acc[m]  <= -1000;
        m_data[m] <= 8'h00;
        m_ovr[m]  <= 1'b0;
      end
    end else begin
      m_prev <= txclk;
      for (int m = 0; m < 2; m++) begin
        if (txclk && !m_prev) begin
          if (!busy(cyc, m_acc[m], m + 1)) begin
            m_acc[m]  <= cyc;
            m_data[m] <= txdata;
            m_ovr[m]  <= 1'b0;
          end else begin
            m_ovr[m] <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge hz100) begin
    check_eq("txd0",     32'(txd0),     32'(exp_txd(cyc, m_acc[0], 1, m_data[0])));
    check_eq("txready0", 32'(txready0), 32'(!busy(cyc, m_acc[0], 1)));
    check_eq("ovr0",     32'(ovr0),     32'(m_ovr[0]));
    check_eq("txd1",     32'(txd1),     32'(exp_txd(cyc, m_acc[1], 2, m_data[1])));
    check_eq("txready1", 32'(txready1), 32'(!busy(cyc, m_acc[1], 2)));
    check_eq("ovr1",     32'(ovr1),     32'(m_ovr[1]));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge hz100);
    #2;
  endtask

  task automatic pulse(input logic [7:0] d);
    txdata = d;
    txclk  = 1'b1;
    tick(1);
    txclk  = 1'b0;
    txdata = 8'($urandom);
  endtask

  initial begin
    logic [7:0] a5;
    logic [9:0] fr;
    a5     = 8'hA5;
    fr     = {((PAR == 1) ? ^a5 : 1'b1), a5, 1'b0};
    reset  = 1'b0;
    txclk  = 1'b0;
    txdata = 8'h00;
    tick(3);
    reset = 1'b1;
    tick(2);

    // A5 frame: sample each bit mid-period.
    pulse(8'hA5);
    tick(1);
    for (int b = 0; b < 10; b++) begin
      #3;
      check_eq("a5_bit", 32'(txd0), 32'(fr[b]));
      if (b == 5) check_eq("a5_busy", 32'(txready0), 32'd0);
      tick(4);
    end
    tick(10);

    // Overrun during a frame, then cleared by the next accepted byte.
    pulse(8'hA5);
    tick(11);
    pulse(8'h3C);
    #3;
    check_eq("ovr_set", 32'(ovr0), 32'd1);
    tick(flen(2));
    check_eq("ovr_sticky", 32'(ovr0), 32'd1);
    pulse(8'h5A);
    #3;
    check_eq("ovr_clear", 32'(ovr0), 32'd0);
    tick(flen(2) + 4);

    // Back-to-back: strobe rises in the cycle txready returns high.
    pulse(8'hA5);
    tick(flen(1));
    #3;
    check_eq("b2b_ready", 32'(txready0), 32'd1);
    pulse(8'h01);
    #3;
    check_eq("b2b_start", 32'(txd0), 32'd0);
    tick(flen(2) + 4);

    // Reset during data bit 3 with txclk held high across release.
    pulse(8'hA5);
    tick(17);
    txclk = 1'b1;
    reset = 1'b0;
    #1;
    check_eq("rst_txd",   32'(txd0),     32'd1);
    check_eq("rst_ready", 32'(txready0), 32'd1);
    tick(2);
    reset = 1'b1;
    tick(12);
    check_eq("held_idle", 32'(txready0), 32'd1);
    txclk = 1'b0;
    tick(1);
    pulse(8'hC3);
    tick(flen(2) + 4);

    // Random strobes, gaps and occasional resets.
    for (int i = 0; i < 60; i++) begin
      tick($urandom_range(0, 50));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        tick($urandom_range(1, 3));
        reset = 1'b1;
      end
      pulse(8'($urandom));
    end
    tick(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
